spdif_frame_serializer: RTL and testbench
=========================================

Name: spdif_frame_serializer

Overview:
- Downstream consumer of the 192-bit consumer-mode Channel Status word. Takes stereo PCM samples through a valid/ready handshake and builds IEC 60958 frames: two 32-slot subframes per frame, 192 frames per block.
- Each subframe carries a preamble, audio, V, U, C and P bits.
- Output is a biphase-mark-coded S/PDIF line, paced by a half-cell clock enable from the clock-generation stage.

Parameters:
- SAMPLE_WIDTH, 24, audio word width (16..24); MSB-justified into slots 4..27.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- halfCellEn  in  1  one-cycle strobe at 128 x fs (one biphase half-cell per strobe)
- channelStatus  in  192  Channel Status word; bit n is carried in frame n
- sampleLeft  in  SAMPLE_WIDTH  subframe A (channel 1) sample, two's complement
- sampleRight  in  SAMPLE_WIDTH  subframe B (channel 2) sample
- sampleValid  in  1  sample pair valid
- sampleReady  out  1  holding register empty
- spdifOut  out  1  biphase-mark line output
- blockStart  out  1  one-cycle pulse when frame 0 begins
- underrun  out  1  one-cycle pulse when a frame starts with no sample pair held

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: spdifOut=0, sampleReady=1, blockStart=0, underrun=0; holding and shift registers empty; halfCell=0, subframe=A, frameCnt=0.
- Pacing: all line state advances only on cycles with halfCellEn=1.
  - spdifOut is registered and changes the cycle after the strobe.
  - The first strobe after reset emits half-cell 0 of frame 0, subframe A.
- Counters:
  - halfCell 0..63 per subframe, then subframe A->B.
  - After B, frameCnt increments and wraps 191->0.
  - One frame = 128 strobes; one block = 24576 strobes.
- Frame-start event: halfCellEn=1 with halfCell=0, subframe A.
  - Holding register full: the pair moves to the frame register and the holding register becomes empty. sampleReady rises the next cycle.
  - Holding register empty: the frame register is zeroed, V=1 in both subframes, and underrun pulses the next cycle.
  - frameCnt=0: channelStatus is latched into the internal 192-bit register, and blockStart pulses the next cycle. Changes to channelStatus mid-block have no effect until the next block.
- Handshake:
  - Accept occurs on sampleValid & sampleReady. sampleReady is registered and drops the cycle after an accept.
  - An accept coinciding with the frame-start event while the holding register is empty fills the holding register for the next frame. The current frame still underruns.
- Subframe slot map:
  - Slots 0-3: preamble, 8 half-cells, not biphase-coded.
  - Slots 4-27: audio, LSB first. With SAMPLE_WIDTH<24, sample bit 0 sits in slot 28-SAMPLE_WIDTH and the lower slots are 0.
  - Slot 28: V (0 = valid sample).
  - Slot 29: U = 0.
  - Slot 30: C = latched channelStatus[frameCnt], identical in A and B.
  - Slot 31: P, chosen so that slots 4..31 contain an even number of ones.
- Preambles (pattern XOR current line level, MSB first):
  - B = 11101000 for subframe A of frame 0.
  - M = 11100010 for subframe A of frames 1..191.
  - W = 11100100 for every subframe B.
- Biphase mark for slots 4..31:
  - The line toggles at the start of every cell.
  - It toggles again mid-cell if the bit is 1.
- State machine, per subframe: PREAMBLE (half-cells 0..7) -> DATA (half-cells 8..63) -> PREAMBLE of the next subframe. The machine never idles: it runs continuously after reset.
- Reset mid-operation has priority over everything else. On the next cycle all outputs and counters take their reset values, any held sample is discarded, and transmission restarts with B.

Test Plan:
1. Reset, no samples, 256 strobes.
   - Half-cells 0..7 = 11101000 (B); subframe B preamble = W.
   - V slot=1 and audio all 0.
   - underrun pulses on strobes 0 and 128.
   - blockStart pulses once.
2. SAMPLE_WIDTH=24, pair L=24'h000001, R=24'h800000 loaded before reset release.
   - Decoded A: slot 4=1, slots 5..27=0, V=0, P=1.
   - Decoded B: slot 27=1, P=1.
   - Every cell boundary shows a transition.
3. channelStatus=192'h...0000_0000_0000_1004 (bit 2 = 1, categoryCode 8'h10 in bits 15..8), held for 2 blocks.
   - Decoded C bits in both subframes reproduce the word across frames 0..191.
   - B appears only in frame 0; M in frames 1..191.
   - blockStart pulses every 24576 strobes.
4. SAMPLE_WIDTH=16, L=16'hABCD.
   - Slots 4..11 = 0.
   - Slots 12..27 = 16'hABCD, LSB first.
   - Parity is even over slots 4..31.
5. sampleValid held high with an incrementing pair count.
   - Exactly one accept per frame; no underrun after the first frame.
   - Decoded samples are in order with none dropped or duplicated.
   - channelStatus changed at frame 50 takes effect only from the next frame 0.
6. Reset asserted at halfCell 37 of frame 10.
   - Next cycle: spdifOut=0, sampleReady=1.
   - First strobe after release starts B of frame 0; the held sample is discarded, so underrun pulses.

Source files
------------

// File: rtl/spdif_frame_serializer.sv
// IEC 60958 consumer-mode frame builder and biphase-mark line driver.
// Stereo PCM pairs arrive over valid/ready; the line advances one half-cell per halfCellEn strobe.
module spdif_frame_serializer #(
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halfCellEn,
  input  logic [191:0]            channelStatus,
  input  logic [SAMPLE_WIDTH-1:0] sampleLeft,
  input  logic [SAMPLE_WIDTH-1:0] sampleRight,
  input  logic                    sampleValid,
  output logic                    sampleReady,
  output logic                    spdifOut,
  output logic                    blockStart,
  output logic                    underrun
);

  // Handshake: a pair is taken on any cycle where sampleValid & sampleReady.
  // sampleReady is registered and equals "holding register empty".

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  typedef enum logic {ST_PREAMBLE, ST_DATA} state_t;

  state_t                  state, state_nxt;
  logic [5:0]              half_cell;
  logic                    sub_b;
  logic [7:0]              frame_cnt;
  logic                    pre_lvl;
  logic                    hold_full, hold_full_nxt;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
  logic [SAMPLE_WIDTH-1:0] frm_l, frm_r;
  logic                    frm_v;
  logic [191:0]            cs_reg;

  logic                    frame_start;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic [23:0]             audio;
  logic                    c_bit;
  logic                    par_bit;
  logic [31:0]             slots;
  logic [4:0]              slot_idx;
  logic                    cell_bit;
  logic [7:0]              pat;
  logic                    pre_base;
  logic                    pre_bit;
  logic                    line_nxt;

  assign frame_start = halfCellEn & (half_cell == 6'd0) & ~sub_b;
  assign accept      = sampleValid & sampleReady;

  // Samples are MSB-justified so the audio field always spans slots 4..27.
  assign cur_sample = sub_b ? frm_r : frm_l;
  assign audio      = 24'(cur_sample) << (24 - SAMPLE_WIDTH);
  assign c_bit      = cs_reg[frame_cnt];
  assign par_bit    = ^{audio, frm_v, c_bit};
  assign slots      = {par_bit, c_bit, 1'b0, frm_v, audio, 4'b0000};
  assign slot_idx   = half_cell[5:1];
  assign cell_bit   = slots[slot_idx];

  // Preamble polarity follows the line level left by the previous subframe,
  // which is the live output on half-cell 0 and the latched copy afterwards.
  assign pat      = sub_b ? PRE_W : ((frame_cnt == 8'd0) ? PRE_B : PRE_M);
  assign pre_base = (half_cell == 6'd0) ? spdifOut : pre_lvl;
  assign pre_bit  = pat[3'd7 - half_cell[2:0]] ^ pre_base;

  always_comb begin
    state_nxt = state;
    line_nxt  = spdifOut;
    if (halfCellEn) begin
      case (state)
        ST_PREAMBLE: begin
          line_nxt = pre_bit;
          if (half_cell == 6'd7) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (!half_cell[0]) line_nxt = ~spdifOut;
          else               line_nxt = spdifOut ^ cell_bit;
          if (half_cell == 6'd63) state_nxt = ST_PREAMBLE;
        end
        default: state_nxt = ST_PREAMBLE;
      endcase
    end
  end

  always_comb begin
    hold_full_nxt = hold_full;
    if (accept)           hold_full_nxt = 1'b1;
    else if (frame_start) hold_full_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PREAMBLE;
      half_cell   <= 6'd0;
      sub_b       <= 1'b0;
      frame_cnt   <= 8'd0;
      pre_lvl     <= 1'b0;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      frm_l       <= '0;
      frm_r       <= '0;
      frm_v       <= 1'b1;
      cs_reg      <= '0;
      spdifOut    <= 1'b0;
      sampleReady <= 1'b1;
      blockStart  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      blockStart <= 1'b0;
      underrun   <= 1'b0;
      if (halfCellEn) begin
        spdifOut  <= line_nxt;
        half_cell <= half_cell + 6'd1;
        if (half_cell == 6'd0) pre_lvl <= spdifOut;
        if (half_cell == 6'd63) begin
          sub_b <= ~sub_b;
          if (sub_b) frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
        end
      end
      if (frame_start) begin
        if (frame_cnt == 8'd0) begin
          cs_reg     <= channelStatus;
          blockStart <= 1'b1;
        end
        if (hold_full) begin
          frm_l <= hold_l;
          frm_r <= hold_r;
          frm_v <= 1'b0;
        end else begin
          frm_l    <= '0;
          frm_r    <= '0;
          frm_v    <= 1'b1;
          underrun <= 1'b1;
        end
      end
      if (accept) begin
        hold_l <= sampleLeft;
        hold_r <= sampleRight;
      end
      hold_full   <= hold_full_nxt;
      sampleReady <= ~hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_spdif_frame_serializer.sv
// Bench for spdif_frame_serializer: 24-bit and 16-bit instances share stimulus and are
// checked every cycle against a frame-level waveform model, plus decoded literal checks.
module tb_spdif_frame_serializer;

  localparam logic [7:0] PB = 8'b11101000;
  localparam logic [7:0] PM = 8'b11100010;
  localparam logic [7:0] PW = 8'b11100100;
  localparam logic [63:0] T1_A = {8'b11101000, {12{4'b1100}}, 8'b10110010};
  localparam logic [63:0] T1_B = {8'b11100100, {12{4'b1100}}, 8'b10110010};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, halfCellEn, sampleValid;
  logic [191:0] channelStatus;
  logic [23:0]  sampleLeft, sampleRight;
  logic         sampleReady, spdifOut, blockStart, underrun;
  logic         sampleReady16, spdifOut16, blockStart16, underrun16;

  spdif_frame_serializer #(.SAMPLE_WIDTH(24)) dut24 (
    .clk(clk), .reset(reset), .halfCellEn(halfCellEn), .channelStatus(channelStatus),
    .sampleLeft(sampleLeft), .sampleRight(sampleRight), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .spdifOut(spdifOut), .blockStart(blockStart), .underrun(underrun)
  );

  spdif_frame_serializer #(.SAMPLE_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .halfCellEn(halfCellEn), .channelStatus(channelStatus),
    .sampleLeft(sampleLeft[23:8]), .sampleRight(sampleRight[23:8]), .sampleValid(sampleValid),
    .sampleReady(sampleReady16), .spdifOut(spdifOut16), .blockStart(blockStart16),
    .underrun(underrun16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ur_cnt = 0;
  int bs_cnt = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: builds a whole frame's half-cells from the slot rules
  function automatic logic [63:0] build_sub(input logic start, input logic [7:0] pre,
                                            input logic [23:0] aud, input logic v,
                                            input logic c);
    logic [63:0] w;
    logic [31:0] bits;
    logic        lvl;
    bits = {1'b0, c, 1'b0, v, aud, 4'b0000};
    bits[31] = (($countones(bits) % 2) != 0);
    for (int i = 0; i < 8; i++) w[i] = pre[7-i] ^ start;
    lvl = w[7];
    for (int s = 4; s < 32; s++) begin
      lvl = ~lvl;
      w[2*s] = lvl;
      if (bits[s]) lvl = ~lvl;
      w[2*s+1] = lvl;
    end
    return w;
  endfunction

  int           m_hc = 0, m_sub = 0, m_frame = 0;
  logic         m_full = 1'b0;
  logic [23:0]  m_hl, m_hr;
  logic [191:0] m_cs = '0;
  logic [127:0] w24 = '0, w16 = '0;
  logic         e_out = 1'b0, e16 = 1'b0, e_ready = 1'b1, e_bs = 1'b0, e_ur = 1'b0;

  initial forever begin
    logic        acc, cv, c;
    logic [23:0] cl, cr;
    logic [63:0] a, b;
    @(posedge clk);
    if (reset) begin
      m_hc = 0; m_sub = 0; m_frame = 0; m_full = 1'b0;
      e_out = 1'b0; e16 = 1'b0; e_ready = 1'b1; e_bs = 1'b0; e_ur = 1'b0;
    end else begin
      acc  = sampleValid && e_ready;
      e_bs = 1'b0;
      e_ur = 1'b0;
      if (halfCellEn) begin
        if (m_hc == 0 && m_sub == 0) begin
          if (m_frame == 0) begin
            m_cs = channelStatus;
            e_bs = 1'b1;
          end
          if (m_full) begin
            cl = m_hl; cr = m_hr; cv = 1'b0; m_full = 1'b0;
          end else begin
            cl = '0; cr = '0; cv = 1'b1; e_ur = 1'b1;
          end
          c = m_cs[m_frame];
          a = build_sub(e_out, (m_frame == 0) ? PB : PM, cl, cv, c);
          b = build_sub(a[63], PW, cr, cv, c);
          w24 = {b, a};
          a = build_sub(e16, (m_frame == 0) ? PB : PM, {cl[23:8], 8'h00}, cv, c);
          b = build_sub(a[63], PW, {cr[23:8], 8'h00}, cv, c);
          w16 = {b, a};
        end
        e_out = w24[m_sub*64 + m_hc];
        e16   = w16[m_sub*64 + m_hc];
        m_hc++;
        if (m_hc == 64) begin
          m_hc = 0;
          m_sub++;
          if (m_sub == 2) begin
            m_sub = 0;
            m_frame = (m_frame + 1) % 192;
          end
        end
      end
      if (acc) begin
        m_hl = sampleLeft; m_hr = sampleRight; m_full = 1'b1;
      end
      e_ready = !m_full;
    end
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("spdifOut24", spdifOut, e_out);
      check("sampleReady24", sampleReady, e_ready);
      check("blockStart24", blockStart, e_bs);
      check("underrun24", underrun, e_ur);
      check("spdifOut16", spdifOut16, e16);
      check("sampleReady16", sampleReady16, e_ready);
      check("blockStart16", blockStart16, e_bs);
      check("underrun16", underrun16, e_ur);
      ur_cnt += int'(underrun);
      bs_cnt += int'(blockStart);
    end
  end

  // sample feeder: 0 idle, 1 incrementing stream, 2 fixed pair, 3 random
  int          feed_mode = 0;
  logic [23:0] fix_l = '0, fix_r = '0;
  logic [15:0] feed_cnt = 16'd0;
  logic        acc_q = 1'b0;

  initial forever begin
    @(posedge clk);
    acc_q = sampleValid & sampleReady & ~reset;
  end

  initial begin
    sampleValid = 1'b0; sampleLeft = '0; sampleRight = '0;
    forever begin
      @(negedge clk);
      case (feed_mode)
        1: begin
          if (acc_q) feed_cnt++;
          sampleValid = 1'b1;
          sampleLeft  = {feed_cnt, feed_cnt[7:0] ^ 8'h3C};
          sampleRight = ~sampleLeft;
        end
        2: begin
          sampleValid = 1'b1; sampleLeft = fix_l; sampleRight = fix_r;
        end
        3: begin
          if (acc_q || !sampleValid) begin
            sampleLeft = 24'($urandom); sampleRight = 24'($urandom);
          end
          sampleValid = 1'($urandom_range(1, 0));
        end
        default: sampleValid = 1'b0;
      endcase
    end
  end

  // driver tasks
  logic [63:0] cap24 = '0, cap16 = '0;

  task automatic strobes(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      halfCellEn = 1'b1;
      @(negedge clk);
      halfCellEn = 1'b0;
      cap24 = {cap24[62:0], spdifOut};
      cap16 = {cap16[62:0], spdifOut16};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [27:0] decode(input logic [63:0] cw);
    logic [27:0] d;
    for (int s = 4; s < 32; s++) d[s-4] = cw[63-2*s] ^ cw[62-2*s];
    return d;
  endfunction

  function automatic logic all_trans(input logic [63:0] cw);
    logic ok;
    ok = 1'b1;
    for (int s = 4; s < 32; s++) if (cw[63-2*s] == cw[64-2*s]) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    int u0, b0;
    logic [27:0] d;
    reset = 1'b1; halfCellEn = 1'b0; channelStatus = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_spdifOut", spdifOut, 1'b0);
    check("reset_sampleReady", sampleReady, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // idle line: B / W preambles, V=1, silent audio, underrun each frame
    u0 = ur_cnt; b0 = bs_cnt;
    strobes(64, 2);
    check("t1_sub_a24", cap24, T1_A);
    check("t1_sub_a16", cap16, T1_A);
    strobes(64, 2);
    check("t1_sub_b24", cap24, T1_B);
    check("t1_sub_b16", cap16, T1_B);
    strobes(128, 2);
    @(negedge clk);
    check("t1_underruns", 64'(ur_cnt - u0), 64'd2);
    check("t1_blockstarts", 64'(bs_cnt - b0), 64'd1);

    // single-bit samples at the audio extremes
    fix_l = 24'h000001; fix_r = 24'h800000; feed_mode = 2;
    do_reset();
    strobes(64, 1);
    check("t2_a_slots24", decode(cap24), 28'h8000001);
    check("t2_a_slots16", decode(cap16), 28'h0000000);
    check("t2_a_transitions", all_trans(cap24), 1'b1);
    strobes(64, 1);
    check("t2_b_slots24", decode(cap24), 28'h8800000);
    check("t2_b_slots16", decode(cap16), 28'h8800000);
    check("t2_b_transitions", all_trans(cap16), 1'b1);

    // 16-bit justification and parity
    fix_l = 24'hABCD00; fix_r = 24'h123400;
    do_reset();
    strobes(64, 3);
    d = decode(cap16);
    check("t4_a_slots16", d, 28'h0ABCD00);
    check("t4_parity16", 64'($countones(d) % 2), 64'd0);
    check("t4_a_slots24", decode(cap24), 28'h0ABCD00);
    strobes(320, 3);

    // continuous stream over a full block, channel status changed mid-block
    channelStatus = 192'h1004;
    feed_mode = 1;
    do_reset();
    u0 = ur_cnt; b0 = bs_cnt;
    strobes(50 * 128, 0);
    channelStatus = {6{$urandom()}};
    strobes(142 * 128 + 3 * 128, 0);
    @(negedge clk);
    check("t5_no_underrun", 64'(ur_cnt - u0), 64'd0);
    check("t5_blockstarts", 64'(bs_cnt - b0), 64'd2);

    // random valid pattern and strobe spacing
    feed_mode = 3;
    channelStatus = {6{$urandom()}};
    do_reset();
    strobes(700, 3);

    // reset in the middle of frame 10 with a pair held
    channelStatus = '0;
    feed_mode = 1;
    do_reset();
    strobes(10 * 128 + 37, 1);
    reset = 1'b1; feed_mode = 0; halfCellEn = 1'b1;
    @(negedge clk);
    halfCellEn = 1'b0;
    check("t6_reset_spdifOut", spdifOut, 1'b0);
    check("t6_reset_sampleReady", sampleReady, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    u0 = ur_cnt;
    strobes(64, 1);
    @(negedge clk);
    check("t6_underrun_after_reset", 64'(ur_cnt - u0), 64'd1);
    check("t6_restart_b24", cap24, T1_A);
    check("t6_restart_b16", cap16, T1_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
